// File: rtl/reporte_uart_pkg.sv
// rtl/reporte_uart_pkg.sv - shared state encoding, ASCII constants and code mapping for reporte_uart
package reporte_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] CH_NONE = 8'h2D;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_G    = 8'h47;
    localparam logic [7:0] CH_B    = 8'h42;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_C    = 8'h43;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    localparam logic [1:0] COL_NONE  = 2'd0;
    localparam logic [1:0] COL_RED   = 2'd1;
    localparam logic [1:0] COL_GREEN = 2'd2;
    localparam logic [1:0] COL_BLUE  = 2'd3;

    localparam logic [1:0] FIG_NONE     = 2'd0;
    localparam logic [1:0] FIG_TRIANGLE = 2'd1;
    localparam logic [1:0] FIG_CIRCLE   = 2'd2;
    localparam logic [1:0] FIG_SQUARE   = 2'd3;

    function automatic logic [7:0] enc_color(input logic [1:0] code);
        case (code)
            COL_RED:   enc_color = CH_R;
            COL_GREEN: enc_color = CH_G;
            COL_BLUE:  enc_color = CH_B;
            default:   enc_color = CH_NONE;
        endcase
    endfunction

    function automatic logic [7:0] enc_figure(input logic [1:0] code);
        case (code)
            FIG_TRIANGLE: enc_figure = CH_T;
            FIG_CIRCLE:   enc_figure = CH_C;
            FIG_SQUARE:   enc_figure = CH_S;
            default:      enc_figure = CH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reporte_uart_if.sv
// rtl/reporte_uart_if.sv - result input and UART report status bundle
interface reporte_uart_if;
    logic       done;
    logic [1:0] color;
    logic [1:0] figure;
    logic       tx;
    logic       busy;
    logic       sent;
    logic       dropped;

    modport master (output done, color, figure, input tx, busy, sent, dropped);
    modport slave  (input done, color, figure, output tx, busy, sent, dropped);
endinterface

// File: rtl/reporte_uart_tx_byte.sv
// rtl/reporte_uart_tx_byte.sv - 8N1 byte serialiser with load/ready handshake
module uart_tx_byte
    import reporte_uart_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);
    // Ready in the last stop cycle too, so back-to-back bytes have no gap.
    assign ready   = (state == ST_IDLE) || (state == ST_STOP && bit_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (load) begin
                        shreg <= data;
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (load) begin
                            shreg <= data;
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/reporte_uart.sv
// rtl/reporte_uart.sv - sends "<colour><figure>\r\n" over UART on each rising edge of done
module reporte_uart
    import reporte_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic          clk,
    input  logic          rst,
    reporte_uart_if.slave bus
);

    localparam int DIV = CLK_FREQ / BAUD;

    logic       done_q;
    logic [1:0] byte_idx;
    logic [7:0] fig_q;
    logic       trigger;
    logic       tx_ready;
    logic       frame_end;
    logic       load;
    logic [7:0] load_data;

    assign trigger   = bus.done & ~done_q;
    assign frame_end = bus.busy & tx_ready;

    // Byte 0 is encoded straight from the inputs so the start bit leaves on the trigger edge.
    always_comb begin
        load      = 1'b0;
        load_data = enc_color(bus.color);
        if (!bus.busy) begin
            load = trigger;
        end else if (frame_end && byte_idx != 2'd3) begin
            load = 1'b1;
            case (byte_idx)
                2'd0:    load_data = fig_q;
                2'd1:    load_data = CH_CR;
                default: load_data = CH_LF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b1;
            byte_idx    <= '0;
            fig_q       <= CH_NONE;
            bus.busy    <= 1'b0;
            bus.sent    <= 1'b0;
            bus.dropped <= 1'b0;
        end else begin
            done_q      <= bus.done;
            bus.sent    <= 1'b0;
            bus.dropped <= trigger & bus.busy;
            if (!bus.busy) begin
                if (trigger) begin
                    bus.busy <= 1'b1;
                    byte_idx <= '0;
                    fig_q    <= enc_figure(bus.figure);
                end
            end else if (frame_end) begin
                if (byte_idx == 2'd3) begin
                    bus.busy <= 1'b0;
                    bus.sent <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (load_data),
        .ready (tx_ready),
        .tx    (bus.tx)
    );

endmodule
